stream_bert: RTL and testbench

//  Parametrised bit-error-rate tester for the encoder/decoder chain. The source side paces a

---
 rtl/stream_bert_pkg.sv | 15 +
 rtl/bert_pattern_gen.sv | 87 ++++++++
 rtl/stream_bert.sv | 237 +++++++++++++++++++++++
 tb/tb_stream_bert.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_bert_pkg.sv
// stream_bert_pkg
//   Shared types and constants for the stream_bert bit-error-rate tester.
//   src_state_t : source pacing FSM states
//   snk_state_t : sink alignment FSM states
//   PRBS7_TAPS  : feedback taps of x^7+x^6+1 (used when STREAM_BERT_PRBS_EN is defined)
//   PRBS7_SEED  : LFSR reset value
package stream_bert_pkg;

  typedef enum logic [1:0] {IDLE, SEND, GAP} src_state_t;
  typedef enum logic {SEARCH, LOCK} snk_state_t;

  localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;
  localparam logic [6:0] PRBS7_SEED = 7'h7F;

endpackage

// File: rtl/bert_pattern_gen.sv
// bert_pattern_gen
//   Produces the current bit of the test sequence and steps it on demand.
//   Fixed mode walks PAT_INIT MSB first; with STREAM_BERT_PRBS_EN defined and
//   mode_i=1 the bit comes from a PRBS-7 LFSR instead.
// Ports
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   mode_i        : 0 = fixed pattern, 1 = PRBS-7 (PRBS build only)
//   advance_i     : step to the next bit
//   load_i        : restart the fixed pattern at index 0 and seed the LFSR
//   load_bits_i   : the last 7 received bits, newest at bit 0 (LFSR seed on load)
//   bit_o         : current sequence bit
// Macro: STREAM_BERT_PRBS_EN enables the LFSR.
module bert_pattern_gen
  import stream_bert_pkg::*;
#(
  parameter int                   PAT_WIDTH = 32,
  parameter logic [PAT_WIDTH-1:0] PAT_INIT  = 32'h0200af31
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       mode_i,
  input  logic       advance_i,
  input  logic       load_i,
  input  logic [6:0] load_bits_i,
  output logic       bit_o
);

  localparam int             IDX_W    = $clog2(PAT_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_WIDTH - 1);

  logic [IDX_W-1:0] idx_q, idx_d, bit_pos;
  logic             fixed_bit;

  always_comb begin
    idx_d = idx_q;
    if (load_i) begin
      idx_d = '0;
    end else if (advance_i) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  // Index 0 is the MSB of the pattern.
  assign bit_pos   = LAST_IDX - idx_q;
  assign fixed_bit = PAT_INIT[bit_pos];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

`ifdef STREAM_BERT_PRBS_EN
  logic [6:0] lfsr_q, lfsr_d;
  logic       prbs_bit;

  // The register holds the last 7 output bits, newest at bit 0, so the sink
  // can seed its copy directly from the 7 bits it has just received.
  assign prbs_bit = ^(lfsr_q & PRBS7_TAPS);

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = load_bits_i;
    end else if (advance_i) begin
      lfsr_d = {lfsr_q[5:0], prbs_bit};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= PRBS7_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit_o = mode_i ? prbs_bit : fixed_bit;
`else
  logic unused_prbs_inputs;
  assign unused_prbs_inputs = ^{mode_i, load_bits_i};
  assign bit_o = fixed_bit;
`endif

endmodule

// File: rtl/stream_bert.sv
// stream_bert
//   Bit-error-rate tester: the source paces a repeating pattern onto an
//   AXI-stream master (payload in TDATA[0]); the sink aligns to the returned
//   stream, tracks lock and counts compared bits and bit errors.
// Ports
//   ap_clk, ap_rst_n          : clock, asynchronous active-low reset
//   enable                    : source run/stop (a pending beat always completes)
//   gap                       : idle cycles after each accepted beat
//   mode                      : 0 = fixed pattern, 1 = PRBS-7 (PRBS build only)
//   clear                     : synchronous clear of bit_count/err_count
//   m_axis_tvalid/tready/tdata: source stream
//   s_axis_tvalid/tready/tdata: sink stream (tready tied high)
//   locked                    : sink aligned
//   bit_count, err_count      : saturating counters of compared bits / errors
// Macro: STREAM_BERT_PRBS_EN enables PRBS-7 generation and self-synchronising sink.
module stream_bert
  import stream_bert_pkg::*;
#(
  parameter int                   PAT_WIDTH = 32,
  parameter logic [PAT_WIDTH-1:0] PAT_INIT  = 32'h0200af31,
  parameter int                   DATA_W    = 8,
  parameter int                   GAP_W     = 4,
  parameter int                   CNT_W     = 32,
  parameter int                   LOSS_THR  = 8
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              enable,
  input  logic [GAP_W-1:0]  gap,
  input  logic              mode,
  input  logic              clear,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [DATA_W-1:0] s_axis_tdata,
  output logic              locked,
  output logic [CNT_W-1:0]  bit_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam int               WIN_W    = $clog2(PAT_WIDTH);
  localparam int               ERR_W    = $clog2(LOSS_THR + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(PAT_WIDTH - 1);
  localparam logic [ERR_W-1:0] LOSS_LIM = ERR_W'(LOSS_THR);

  // ---------------- source ----------------
  src_state_t       src_q, src_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             src_hs, src_bit;

  assign src_hs = (src_q == SEND) && m_axis_tready;

  always_comb begin
    src_d     = src_q;
    gap_cnt_d = gap_cnt_q;
    case (src_q)
      IDLE: if (enable) src_d = SEND;
      SEND: begin
        if (m_axis_tready) begin
          if (!enable) begin
            src_d = IDLE;
          end else if (gap != '0) begin
            src_d     = GAP;
            gap_cnt_d = gap;
          end
        end
      end
      GAP: begin
        if (!enable) begin
          src_d = IDLE;
        end else if (gap_cnt_q <= GAP_W'(1)) begin
          src_d = SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: src_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      src_q     <= IDLE;
      gap_cnt_q <= '0;
    end else begin
      src_q     <= src_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  bert_pattern_gen #(.PAT_WIDTH(PAT_WIDTH), .PAT_INIT(PAT_INIT)) u_src_gen (
    .clk_i      (ap_clk),
    .rst_ni     (ap_rst_n),
    .mode_i     (mode),
    .advance_i  (src_hs),
    .load_i     (1'b0),
    .load_bits_i(7'd0),
    .bit_o      (src_bit)
  );

  assign m_axis_tvalid = (src_q == SEND);
  // Gate with tvalid so TDATA reads 0 whenever no beat is offered.
  assign m_axis_tdata  = {{(DATA_W-1){1'b0}}, src_bit & m_axis_tvalid};

  // ---------------- sink ----------------
  snk_state_t       snk_q, snk_d;
  logic [PAT_WIDTH-1:0] sr_q, sr_d, sr_shift;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [ERR_W-1:0] win_err_q, win_err_d, win_err_sum;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d, err_cnt_q, err_cnt_d;
  logic             rx_bit, exp_bit, miss, acq, snk_load, bit_inc, err_inc;

  assign rx_bit      = s_axis_tdata[0];
  assign sr_shift    = {sr_q[PAT_WIDTH-2:0], rx_bit};
  assign miss        = rx_bit ^ exp_bit;
  assign win_err_sum = win_err_q + ERR_W'(miss);

`ifdef STREAM_BERT_PRBS_EN
  logic [2:0] srch_q, srch_d;
  // PRBS lock needs only 7 received bits to seed the local LFSR.
  assign acq = mode ? (srch_q == 3'd6) : (sr_shift == PAT_INIT);
`else
  assign acq = (sr_shift == PAT_INIT);
`endif

  always_comb begin
    snk_d     = snk_q;
    sr_d      = sr_q;
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    snk_load  = 1'b0;
    bit_inc   = 1'b0;
    err_inc   = 1'b0;
`ifdef STREAM_BERT_PRBS_EN
    srch_d    = srch_q;
`endif
    case (snk_q)
      SEARCH: begin
        if (s_axis_tvalid) begin
          sr_d = sr_shift;
`ifdef STREAM_BERT_PRBS_EN
          srch_d = srch_q + 1'b1;
`endif
          if (acq) begin
            snk_d     = LOCK;
            snk_load  = 1'b1;
            win_cnt_d = '0;
            win_err_d = '0;
`ifdef STREAM_BERT_PRBS_EN
            srch_d    = '0;
`endif
          end
        end
      end
      LOCK: begin
        if (s_axis_tvalid) begin
          bit_inc = 1'b1;
          err_inc = miss;
          if (win_err_sum >= LOSS_LIM) begin
            snk_d = SEARCH;
            sr_d  = '0;
`ifdef STREAM_BERT_PRBS_EN
            srch_d = '0;
`endif
          end else if (win_cnt_q == WIN_LAST) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            win_err_d = win_err_sum;
          end
        end
      end
      default: snk_d = SEARCH;
    endcase

    // clear has priority over a same-cycle increment; counters stick at all-ones.
    bit_cnt_d = bit_cnt_q;
    err_cnt_d = err_cnt_q;
    if (clear) begin
      bit_cnt_d = '0;
      err_cnt_d = '0;
    end else begin
      if (bit_inc && (bit_cnt_q != '1)) bit_cnt_d = bit_cnt_q + 1'b1;
      if (err_inc && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      snk_q     <= SEARCH;
      sr_q      <= '0;
      win_cnt_q <= '0;
      win_err_q <= '0;
      bit_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      snk_q     <= snk_d;
      sr_q      <= sr_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
      bit_cnt_q <= bit_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

`ifdef STREAM_BERT_PRBS_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      srch_q <= '0;
    end else begin
      srch_q <= srch_d;
    end
  end
`endif

  bert_pattern_gen #(.PAT_WIDTH(PAT_WIDTH), .PAT_INIT(PAT_INIT)) u_snk_gen (
    .clk_i      (ap_clk),
    .rst_ni     (ap_rst_n),
    .mode_i     (mode),
    .advance_i  (s_axis_tvalid && (snk_q == LOCK)),
    .load_i     (snk_load),
    .load_bits_i(sr_shift[6:0]),
    .bit_o      (exp_bit)
  );

  logic unused_tdata_hi;
  assign unused_tdata_hi = ^s_axis_tdata[DATA_W-1:1];

  assign s_axis_tready = 1'b1;
  assign locked        = (snk_q == LOCK);
  assign bit_count     = bit_cnt_q;
  assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_stream_bert.sv
// tb_stream_bert
//   Loopback bench for stream_bert: source beats are checked against a queue
//   of expected pattern bits by a monitor; sink lock/counters are checked at
//   hand-computed points. Define STREAM_BERT_PRBS_EN to add the PRBS lock check.
module tb_stream_bert;

  localparam logic [31:0] PAT = 32'h0200af31;

  logic        ap_clk, ap_rst_n, enable, mode, clear, flip;
  logic [3:0]  gap;
  logic        m_tvalid, m_tready, s_tvalid, s_tready, locked;
  logic [7:0]  m_tdata, s_tdata;
  logic [31:0] bit_count, err_count;

  int n_cmp = 0;
  int n_bad = 0;
  int pidx  = 0;
  int cyc   = 0;
  bit gap_chk = 0;
  bit exp_q[$];

  assign s_tvalid = m_tvalid & m_tready;
  assign s_tdata  = m_tdata ^ {7'b0, flip};

  stream_bert dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .enable       (enable),
    .gap          (gap),
    .mode         (mode),
    .clear        (clear),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tdata (m_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tdata (s_tdata),
    .locked       (locked),
    .bit_count    (bit_count),
    .err_count    (err_count)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ap_clk);
      #1;
    end
  endtask

  task automatic push_pat(input int n);
    logic [31:0] pv;
    pv = PAT;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(pv[31-pidx]);
      pidx = (pidx + 1) % 32;
    end
  endtask

  // Monitor: samples mid-cycle, away from the active edge.
  initial begin
    bit         prev_v, prev_r, e;
    logic [7:0] prev_d;
    int         last_hs;
    prev_v = 0; prev_r = 0; prev_d = '0; last_hs = -1;
    forever begin
      @(negedge ap_clk);
      cyc++;
      if (!ap_rst_n) begin
        prev_v  = 0;
        last_hs = -1;
      end else begin
        if (prev_v && !prev_r) begin
          chk("hold_valid", {31'b0, m_tvalid}, 32'd1);
          chk("hold_data", {24'b0, m_tdata}, {24'b0, prev_d});
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("beat_data", {24'b0, m_tdata}, {31'b0, e});
          end
          if (gap_chk && last_hs >= 0) chk("hs_spacing", cyc - last_hs, 32'd4);
          last_hs = cyc;
        end
        prev_v = m_tvalid;
        prev_r = m_tready;
        prev_d = m_tdata;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    ap_rst_n = 0; enable = 0; gap = 0; mode = 0; clear = 0; m_tready = 0; flip = 0;
    push_pat(1500);
    tick(3);
    chk("rst_tvalid", {31'b0, m_tvalid}, 0);
    chk("rst_tdata", {24'b0, m_tdata}, 0);
    chk("rst_sready", {31'b0, s_tready}, 1);
    chk("rst_locked", {31'b0, locked}, 0);
    chk("rst_bits", bit_count, 0);
    chk("rst_errs", err_count, 0);
    ap_rst_n = 1;
    tick(2);

    // Test 1: loopback, continuous beats
    m_tready = 1;
    enable   = 1;
    chk("pre_valid", {31'b0, m_tvalid}, 0);
    tick(1);
    chk("valid_rise", {31'b0, m_tvalid}, 1);
    chk("first_bit", {24'b0, m_tdata}, 0);
    tick(31);
    chk("lock_31", {31'b0, locked}, 0);
    tick(1);
    chk("lock_32", {31'b0, locked}, 1);
    chk("bits_at_lock", bit_count, 0);
    tick(168);
    chk("t1_bits", bit_count, 168);
    chk("t1_errs", err_count, 0);

    // Test 4: sparse single-bit errors
    for (int i = 0; i < 4; i++) begin
      tick(50);
      flip = 1;
      tick(1);
      flip = 0;
      tick(49);
    end
    chk("t4_locked", {31'b0, locked}, 1);
    chk("t4_errs", err_count, 4);
    chk("t4_bits", bit_count, 568);

    // Test 5: 8 errors at pattern index 24..31 force loss of lock
    flip = 1;
    tick(7);
    chk("t5_still_locked", {31'b0, locked}, 1);
    tick(1);
    flip = 0;
    chk("t5_lost", {31'b0, locked}, 0);
    chk("t5_errs", err_count, 12);
    chk("t5_bits", bit_count, 576);
    tick(31);
    chk("t5_relock_31", {31'b0, locked}, 0);
    tick(1);
    chk("t5_relock_32", {31'b0, locked}, 1);
    chk("t5_bits_held", bit_count, 576);
    flip  = 1;
    clear = 1;
    tick(1);
    flip  = 0;
    clear = 0;
    chk("clr_bits", bit_count, 0);
    chk("clr_errs", err_count, 0);
    chk("clr_locked", {31'b0, locked}, 1);
    tick(1);
    chk("post_clr_bits", bit_count, 1);
    chk("post_clr_errs", err_count, 0);

    // Test 2: gap=3
    gap = 3;
    tick(6);
    gap_chk = 1;
    tick(40);
    gap_chk = 0;
    gap = 0;
    tick(4);

    // Test 3: random backpressure
    for (int i = 0; i < 300; i++) begin
      m_tready = 1'($urandom_range(0, 1));
      tick(1);
    end
    chk("t3_locked", {31'b0, locked}, 1);
    chk("t3_errs", err_count, 0);

    // enable=0 never drops a pending beat; index resumes afterwards
    m_tready = 0;
    tick(2);
    chk("pend_valid", {31'b0, m_tvalid}, 1);
    enable = 0;
    tick(3);
    chk("pend_hold", {31'b0, m_tvalid}, 1);
    m_tready = 1;
    tick(1);
    chk("stop_idle", {31'b0, m_tvalid}, 0);
    tick(3);
    chk("stop_idle2", {31'b0, m_tvalid}, 0);
    enable = 1;
    tick(1);
    chk("resume_valid", {31'b0, m_tvalid}, 1);
    tick(40);
    chk("resume_errs", err_count, 0);

    // Test 6: asynchronous reset mid-beat
    m_tready = 0;
    tick(2);
    #2;
    ap_rst_n = 0;
    #1;
    chk("arst_tvalid", {31'b0, m_tvalid}, 0);
    chk("arst_tdata", {24'b0, m_tdata}, 0);
    chk("arst_locked", {31'b0, locked}, 0);
    chk("arst_bits", bit_count, 0);
    chk("arst_errs", err_count, 0);
    chk("arst_sready", {31'b0, s_tready}, 1);
    exp_q.delete();
    pidx = 0;
    push_pat(100);
    tick(2);
    ap_rst_n = 1;
    m_tready = 1;
    tick(1);
    chk("arst_first_valid", {31'b0, m_tvalid}, 1);
    chk("arst_first_bit", {24'b0, m_tdata}, 0);
    tick(31);
    chk("arst_lock_31", {31'b0, locked}, 0);
    tick(1);
    chk("arst_lock_32", {31'b0, locked}, 1);
    tick(20);

`ifdef STREAM_BERT_PRBS_EN
    enable = 0;
    tick(3);
    ap_rst_n = 0;
    exp_q.delete();
    mode = 1;
    tick(1);
    ap_rst_n = 1;
    enable = 1;
    tick(1);
    tick(6);
    chk("prbs_lock_6", {31'b0, locked}, 0);
    tick(1);
    chk("prbs_lock_7", {31'b0, locked}, 1);
    tick(100);
    chk("prbs_locked", {31'b0, locked}, 1);
    chk("prbs_errs", err_count, 0);
    chk("prbs_bits", bit_count, 100);
`endif

    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
